// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle unsigned restoring divider. One quotient bit per
//            clock, MSB first, through a single shared subtract/restore
//            datapath. start/busy/done handshake, captured operands, held
//            results and a divide-by-zero flag.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request a division (sampled only while idle)
//            A, B   - dividend / divisor, captured on the accepting edge
//            busy   - high while a division is in progress
//            done   - one-cycle pulse when Q/R/dbz have just been updated
//            Q, R   - quotient / remainder, held until next completion
//            dbz    - divide-by-zero flag of the last completed operation
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_RUN  = 2'd1;
  localparam logic [1:0]       c_FIN  = 2'd2;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  // Partial remainder. Its (WIDTH+1)-th bit is always zero between
  // iterations (P < B always holds), so only WIDTH bits are stored; the
  // extra MSB is carried in w_shift / w_t where it matters.
  logic [WIDTH-1:0] r_p;
  // Dividend bits shift out of the MSB while quotient bits shift in at the
  // LSB; after WIDTH iterations it holds the quotient. On a zero divisor no
  // iterations run, so it still holds A at FIN time.
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_t;
  logic             w_neg;
  logic             w_bzero;

  assign w_shift = {r_p, r_s[WIDTH-1]};
  assign w_t     = w_shift - {1'b0, r_b};
  assign w_neg   = w_t[WIDTH];
  assign w_bzero = (r_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_s     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_s     <= A;
            r_b     <= B;
            r_p     <= '0;
            r_cnt   <= '0;
            // A zero divisor skips the iterations entirely.
            r_state <= (B == '0) ? c_FIN : c_RUN;
          end
        end
        c_RUN: begin
          // Restore when the trial subtraction went negative; the restored
          // value fits in WIDTH bits because it is below B.
          r_p     <= w_neg ? w_shift[WIDTH-1:0] : w_t[WIDTH-1:0];
          r_s     <= {r_s[WIDTH-2:0], ~w_neg};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST) begin
            r_state <= c_FIN;
          end
        end
        c_FIN: begin
          if (w_bzero) begin
            r_q   <= '1;
            r_r   <= r_s;
            r_dbz <= 1'b1;
          end else begin
            r_q   <= r_s;
            r_r   <= r_p;
            r_dbz <= 1'b0;
          end
          r_done  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != c_IDLE);
  assign done = r_done;
  assign Q    = r_q;
  assign R    = r_r;
  assign dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider. Drives a WIDTH=4 and a
//            WIDTH=8 instance and compares results, latency and busy time
//            against a plain-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] A4 = '0, B4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] Q4, R4;

  logic       start8 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0;
  logic       busy8, done8, dbz8;
  logic [7:0] Q8, R8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .Q(Q4), .R(R4), .dbz(dbz4)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8),
    .busy(busy8), .done(done8), .Q(Q8), .R(R8), .dbz(dbz8)
  );

  // Reference model: what a division of a by b must produce.
  function automatic void ref_div(input int w, input int a, input int b,
                                  output int q, output int r, output int z,
                                  output int lat, output int bc);
    if (b == 0) begin
      q = (1 << w) - 1; r = a; z = 1; lat = 1; bc = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = w + 1; bc = w + 1;
    end
  endfunction

  // Drivers: entered at a falling edge. lat is the number of falling edges
  // after the accepting edge until done is seen (-1 on timeout), bc the
  // number of sampled busy cycles. Returns in the done cycle.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int bc);
    A4 = a; B4 = b; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; lat = -1; bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (busy4) bc++;
      if (done4) begin lat = k; break; end
    end
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, output int lat, output int bc);
    A8 = a; B8 = b; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; lat = -1; bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (busy8) bc++;
      if (done8) begin lat = k; break; end
      if (scramble) begin
        A8 = 8'($urandom); B8 = 8'($urandom); start8 = 1'($urandom_range(0, 1));
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy4, done4, Q4, R4, dbz4, busy8, done8, Q8, R8, dbz8} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got b4=%b d4=%b Q4=%0d R4=%0d z4=%b b8=%b d8=%b Q8=%0d R8=%0d z8=%b, want all 0",
               busy4, done4, Q4, R4, dbz4, busy8, done8, Q8, R8, dbz8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy8, done8, Q8, R8, dbz8} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got b=%b d=%b Q=%0d R=%0d z=%b, want all 0",
               busy8, done8, Q8, R8, dbz8);
    end
  endtask

  task automatic test_basic4();
    int lat, bc;
    do_op4(4'd13, 4'd3, lat, bc);
    n_tests++;
    if (lat !== 5 || bc !== 5 || Q4 !== 4'd4 || R4 !== 4'd1 || dbz4 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic4: got lat=%0d busy=%0d Q=%0d R=%0d dbz=%b, want lat=5 busy=5 Q=4 R=1 dbz=0",
               lat, bc, Q4, R4, dbz4);
    end
    @(negedge clk);
    n_tests++;
    if (done4 !== 1'b0 || busy4 !== 1'b0 || Q4 !== 4'd4 || R4 !== 4'd1) begin
      n_fail++;
      $display("FAIL basic4_pulse: got done=%b busy=%b Q=%0d R=%0d, want done=0 busy=0 Q=4 R=1",
               done4, busy4, Q4, R4);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op8(8'd255, 8'd1, 1'b0, lat, bc);
    n_tests++;
    if (lat !== 9 || bc !== 9 || Q8 !== 8'd255 || R8 !== 8'd0 || dbz8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d busy=%0d Q=%0d R=%0d dbz=%b, want lat=9 busy=9 Q=255 R=0 dbz=0",
               lat, bc, Q8, R8, dbz8);
    end
    // Still in the done cycle: the next start must be accepted right away.
    do_op8(8'd200, 8'd7, 1'b0, lat, bc);
    n_tests++;
    if (lat !== 9 || Q8 !== 8'd28 || R8 !== 8'd4 || dbz8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d Q=%0d R=%0d dbz=%b, want lat=9 Q=28 R=4 dbz=0",
               lat, Q8, R8, dbz8);
    end
    @(negedge clk);
  endtask

  task automatic test_dbz();
    int lat, bc;
    do_op8(8'd77, 8'd0, 1'b0, lat, bc);
    n_tests++;
    if (lat !== 1 || bc !== 1 || Q8 !== 8'hFF || R8 !== 8'd77 || dbz8 !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz: got lat=%0d busy=%0d Q=%0h R=%0d dbz=%b, want lat=1 busy=1 Q=ff R=77 dbz=1",
               lat, bc, Q8, R8, dbz8);
    end
    @(negedge clk);
    do_op8(8'd10, 8'd5, 1'b0, lat, bc);
    n_tests++;
    if (lat !== 9 || Q8 !== 8'd2 || R8 !== 8'd0 || dbz8 !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear: got lat=%0d Q=%0d R=%0d dbz=%b, want lat=9 Q=2 R=0 dbz=0",
               lat, Q8, R8, dbz8);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    do_op8(8'd5, 8'd9, 1'b1, lat, bc);
    n_tests++;
    if (lat !== 9 || bc !== 9 || Q8 !== 8'd0 || R8 !== 8'd5 || dbz8 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore: got lat=%0d busy=%0d Q=%0d R=%0d dbz=%b, want lat=9 busy=9 Q=0 R=5 dbz=0",
               lat, bc, Q8, R8, dbz8);
    end
    @(negedge clk);
    n_tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_midop();
    int  lat, bc;
    bit  seen;
    // Leave a nonzero result behind so the reset has something to clear.
    do_op8(8'd10, 8'd3, 1'b0, lat, bc);
    @(negedge clk);
    A8 = 8'd100; B8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy8, done8, Q8, R8, dbz8} !== '0) begin
      n_fail++;
      $display("FAIL reset_midop: got b=%b d=%b Q=%0d R=%0d z=%b, want all 0",
               busy8, done8, Q8, R8, dbz8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: got activity=%b after release, want 0", seen);
    end
    do_op8(8'd100, 8'd3, 1'b0, lat, bc);
    n_tests++;
    if (lat !== 9 || Q8 !== 8'd33 || R8 !== 8'd1 || dbz8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fresh: got lat=%0d Q=%0d R=%0d dbz=%b, want lat=9 Q=33 R=1 dbz=0",
               lat, Q8, R8, dbz8);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep4();
    int lat, bc, eq, er, ez, el, eb;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ref_div(4, a, b, eq, er, ez, el, eb);
        do_op4(4'(a), 4'(b), lat, bc);
        n_tests++;
        if (lat !== el || bc !== eb || int'(Q4) !== eq || int'(R4) !== er || int'(dbz4) !== ez) begin
          n_fail++;
          $display("FAIL sweep4 %0d/%0d: got lat=%0d busy=%0d Q=%0d R=%0d dbz=%b, want lat=%0d busy=%0d Q=%0d R=%0d dbz=%0d",
                   a, b, lat, bc, Q4, R4, dbz4, el, eb, eq, er, ez);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random8();
    int lat, bc, eq, er, ez, el, eb, a, b;
    bit scr;
    for (int i = 0; i < 40; i++) begin
      a   = int'($urandom_range(0, 255));
      b   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      scr = 1'($urandom_range(0, 1));
      ref_div(8, a, b, eq, er, ez, el, eb);
      do_op8(8'(a), 8'(b), scr, lat, bc);
      n_tests++;
      if (lat !== el || bc !== eb || int'(Q8) !== eq || int'(R8) !== er || int'(dbz8) !== ez) begin
        n_fail++;
        $display("FAIL random8 %0d/%0d: got lat=%0d busy=%0d Q=%0d R=%0d dbz=%b, want lat=%0d busy=%0d Q=%0d R=%0d dbz=%0d",
                 a, b, lat, bc, Q8, R8, dbz8, el, eb, eq, er, ez);
      end
      // Sometimes issue the next op straight from the done cycle.
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic4();
    test_back_to_back();
    test_dbz();
    test_busy_ignore();
    test_reset_midop();
    test_sweep4();
    test_random8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised, multi-cycle unsigned restoring divider: the sequential successor to the team's fixed 4-bit combinational divider.
- One shared subtract/restore datapath computes one quotient bit per clock, MSB first, for any WIDTH. This saves area in the ALU.
- Adds a start/busy/done handshake, operand capture, held results and explicit divide-by-zero reporting.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- A  input  WIDTH  dividend; captured on the accepting edge.
- B  input  WIDTH  divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when Q/R/dbz are updated.
- Q  output  WIDTH  quotient, registered, held until the next completion.
- R  output  WIDTH  remainder, registered, held until the next completion.
- dbz  output  1  divide-by-zero flag for the last completed operation, held.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, Q=0, R=0, dbz=0; internal registers cleared. Reset mid-operation aborts the operation and no done is produced.
- States:
  - IDLE: busy=0. An edge with start=1 captures A and B and goes to RUN, or to FIN if B==0.
  - RUN: busy=1, one iteration per edge, WIDTH iterations.
  - FIN: one cycle; results are written, then return to IDLE.
- Datapath: partial remainder P has WIDTH+1 bits (extra MSB, as in the combinational version); shift register S holds the dividend bits. Per iteration:
  - T = {P[WIDTH-1:0], S[WIDTH-1]} - {1'b0, B}, computed in WIDTH+1 bits.
  - If T[WIDTH]==0 (non-negative): P=T and the quotient bit is 1. Otherwise P is restored to {P[WIDTH-1:0], S[WIDTH-1]} and the quotient bit is 0.
  - Quotient bits shift into S from the LSB.
- Latency, with start accepted at edge E:
  - Iterations occur at edges E+1..E+WIDTH, then the FIN edge E+WIDTH+1 loads Q, R and dbz.
  - done=1 during the cycle following E+WIDTH+1, i.e. exactly one cycle; state is IDLE in that cycle.
  - busy=1 in cycles following edges E through E+WIDTH; busy=0 in the done cycle.
- Back-to-back: start=1 during the done cycle is accepted (state is IDLE), so throughput is one result per WIDTH+2 cycles.
- Divide by zero (captured B==0):
  - Skip RUN; FIN at E+1, done visible after E+2.
  - Q = all ones, R = A, dbz=1.
  - Any completion with B!=0 clears dbz.
- Operand capture: A and B may change freely after the accepting edge without effect.
- start while busy: ignored, with no queueing and no error.
- A < B: Q=0, R=A. A==0: Q=0, R=0 (B!=0).
- Q, R and dbz change only at a FIN edge or at reset; they never show intermediate values.
- All arithmetic is unsigned; no overflow is possible for B!=0.

Test Plan:
- WIDTH=4, A=13, B=3, start pulse -> after 6 edges done=1 for exactly one cycle, Q=4, R=1, dbz=0; busy high for exactly 5 cycles.
- WIDTH=8, A=255, B=1 -> Q=255, R=0. Then back-to-back start in the done cycle with A=200, B=7 -> second done 10 cycles later, Q=28, R=4.
- WIDTH=8, A=77, B=0 -> done after 2 edges, Q=8'hFF, R=77, dbz=1. Next op A=10, B=5 -> Q=2, R=0, dbz=0.
- WIDTH=8, A=5, B=9 -> Q=0, R=5. Toggle A/B and start during busy -> no effect on the result or timing.
- Assert rst_n low at iteration 3 of A=100, B=3 -> all outputs 0 immediately; no done after release. A fresh op A=100, B=3 -> Q=33, R=1.
- Exhaustive WIDTH=4 sweep (all 256 A/B pairs) against a reference model -> Q=A/B and R=A%B for B!=0; the B==0 rule for B=0.
